// File: rtl/wrd_feeder_pkg.sv
// Shared wake-word pipeline constants and small helpers.
package wrd_feeder_pkg;

    localparam int WW_COEF_BW     = 8;
    localparam int WW_VECTOR_LEN  = 13;
    localparam int WW_FRAME_LEN   = 50;
    localparam int WW_SAMPLE_HZ   = 16000;
    localparam int WW_HOP_SAMPLES = 320;

    // Counter width for a 0..n-1 range; at least one bit.
    function automatic int cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/wrd_feeder_pack.sv
// Coefficient counter and pack register; presents the completed vector
// combinationally so the output register can load it on the final accept.
module feeder_pack
    import wrd_feeder_pkg::*;
#(
    parameter int BW         = WW_COEF_BW,
    parameter int VECTOR_LEN = WW_VECTOR_LEN
) (
    input  logic                     clk_i,
    input  logic                     rst_n_i,
    input  logic                     clr_i,
    input  logic                     accept_i,
    input  logic [BW-1:0]            coef_i,
    output logic                     last_coef_o,
    output logic                     complete_o,
    output logic [BW*VECTOR_LEN-1:0] vec_o
);

    localparam int CW = cnt_w(VECTOR_LEN);
    localparam logic [CW-1:0] CNT_LAST = CW'(VECTOR_LEN - 1);

    logic [CW-1:0]            cnt_q, cnt_d;
    logic [BW*VECTOR_LEN-1:0] pack_q, pack_d;

    always_comb begin
        vec_o = pack_q;
        vec_o[BW*cnt_q +: BW] = coef_i;
    end

    assign last_coef_o = (cnt_q == CNT_LAST);
    assign complete_o  = accept_i && last_coef_o;

    always_comb begin
        cnt_d  = cnt_q;
        pack_d = pack_q;
        if (clr_i) begin
            cnt_d  = '0;
            pack_d = '0;
        end else if (accept_i) begin
            pack_d = vec_o;
            cnt_d  = last_coef_o ? '0 : cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            cnt_q  <= '0;
            pack_q <= '0;
        end else begin
            cnt_q  <= cnt_d;
            pack_q <= pack_d;
        end
    end

endmodule

// File: rtl/wrd_feeder.sv
// Packs a serial coefficient stream into vectors for the word-recognition
// engine; pack + output registers form a 2-entry buffer, frames of FRAME_LEN.
module wrd_feeder
    import wrd_feeder_pkg::*;
#(
    parameter int BW         = WW_COEF_BW,
    parameter int VECTOR_LEN = WW_VECTOR_LEN,
    parameter int FRAME_LEN  = WW_FRAME_LEN
) (
    input  logic                     clk_i,
    input  logic                     rst_n_i,
    input  logic [BW-1:0]            coef_i,
    input  logic                     coef_valid_i,
    output logic                     coef_ready_o,
    input  logic                     flush_i,
    output logic [BW*VECTOR_LEN-1:0] data_o,
    output logic                     valid_o,
    output logic                     last_o,
    input  logic                     ready_i,
    output logic                     frame_done_o
);

    localparam int FW = cnt_w(FRAME_LEN);
    localparam logic [FW-1:0] FRM_LAST = FW'(FRAME_LEN - 1);

    logic                     en_q;
    logic                     valid_q, valid_d;
    logic [BW*VECTOR_LEN-1:0] data_q, data_d;
    logic [FW-1:0]            frm_q, frm_d;
    logic                     accept, last_coef, complete, hs, frame_end;
    logic [BW*VECTOR_LEN-1:0] vec;

    feeder_pack #(.BW(BW), .VECTOR_LEN(VECTOR_LEN)) u_pack (
        .clk_i       (clk_i),
        .rst_n_i     (rst_n_i),
        .clr_i       (flush_i),
        .accept_i    (accept),
        .coef_i      (coef_i),
        .last_coef_o (last_coef),
        .complete_o  (complete),
        .vec_o       (vec)
    );

    // A completing accept is only blocked when the output register cannot drain.
    assign coef_ready_o = en_q && !flush_i && !(last_coef && valid_q && !ready_i);
    assign accept       = coef_valid_i && coef_ready_o;
    assign hs           = valid_q && ready_i && !flush_i;
    assign frame_end    = (frm_q == FRM_LAST);

    assign data_o       = data_q;
    assign valid_o      = valid_q;
    assign last_o       = valid_q && frame_end;
    assign frame_done_o = hs && frame_end;

    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        frm_d   = frm_q;
        if (flush_i) begin
            valid_d = 1'b0;
            frm_d   = '0;
        end else begin
            if (hs) begin
                valid_d = 1'b0;
                frm_d   = frame_end ? '0 : frm_q + FW'(1);
            end
            if (complete) begin
                valid_d = 1'b1;
                data_d  = vec;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            en_q    <= 1'b0;
            valid_q <= 1'b0;
            data_q  <= '0;
            frm_q   <= '0;
        end else begin
            en_q    <= 1'b1;
            valid_q <= valid_d;
            data_q  <= data_d;
            frm_q   <= frm_d;
        end
    end

endmodule

// File: tb/tb_wrd_feeder.sv
// Directed + randomized bench for wrd_feeder against a queue-based model.
module tb_wrd_feeder;

    localparam int BW = 8;
    localparam int VL = 13;
    localparam int FL = 50;
    localparam int DW = BW * VL;

    logic          clk = 1'b0;
    logic          rst_n_i;
    logic [BW-1:0] coef_i;
    logic          coef_valid_i;
    logic          coef_ready_o;
    logic          flush_i;
    logic [DW-1:0] data_o;
    logic          valid_o;
    logic          last_o;
    logic          ready_i;
    logic          frame_done_o;

    always #5 clk = ~clk;

    wrd_feeder #(.BW(BW), .VECTOR_LEN(VL), .FRAME_LEN(FL)) dut (
        .clk_i        (clk),
        .rst_n_i      (rst_n_i),
        .coef_i       (coef_i),
        .coef_valid_i (coef_valid_i),
        .coef_ready_o (coef_ready_o),
        .flush_i      (flush_i),
        .data_o       (data_o),
        .valid_o      (valid_o),
        .last_o       (last_o),
        .ready_i      (ready_i),
        .frame_done_o (frame_done_o)
    );

    int errors = 0;
    int checks = 0;

    logic [BW-1:0] part[$];
    logic [DW-1:0] oq[$];
    int            idx = 0;
    bit            armed = 0;
    int            acc_cnt = 0;
    int            fd_seen = 0;
    int            hs_seen = 0;
    int            last_at = -1;

    task automatic chk(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic void model_clear();
        part.delete();
        oq.delete();
        idx = 0;
    endfunction

    task automatic step(input logic v, input logic [BW-1:0] c, input logic rdy, input logic fl);
        logic          exp_rdy, hs;
        logic [DW-1:0] vec;
        coef_valid_i = v;
        coef_i       = c;
        ready_i      = rdy;
        flush_i      = fl;
        #1;
        exp_rdy = armed && !fl && !(part.size() == VL-1 && oq.size() != 0 && !rdy);
        hs      = (oq.size() != 0) && rdy && !fl;
        chk("coef_ready", coef_ready_o, exp_rdy);
        chk("valid", valid_o, oq.size() != 0);
        if (oq.size() != 0) begin
            chk("data", data_o, oq[0]);
            chk("last", last_o, idx == FL-1);
        end else begin
            chk("last_idle", last_o, 0);
        end
        chk("frame_done", frame_done_o, hs && idx == FL-1);
        if (frame_done_o) fd_seen++;
        if (valid_o && rdy && !fl) begin
            hs_seen++;
            if (last_o) last_at = hs_seen;
        end
        if (fl) begin
            model_clear();
        end else begin
            if (hs) begin
                void'(oq.pop_front());
                idx = (idx == FL-1) ? 0 : idx + 1;
            end
            if (v && exp_rdy) begin
                acc_cnt++;
                part.push_back(c);
                if (part.size() == VL) begin
                    vec = '0;
                    for (int k = 0; k < VL; k++) vec[BW*k +: BW] = part[k];
                    oq.push_back(vec);
                    part.delete();
                end
            end
        end
        @(posedge clk);
        #1;
        armed = rst_n_i;
    endtask

    // Feeds n accepted random coefficients with random valid gaps.
    task automatic feed_rand(input int n, input logic rdy);
        int target;
        int budget;
        target = acc_cnt + n;
        budget = n * 8 + 20;
        while (acc_cnt < target && budget > 0) begin
            step($urandom_range(0, 3) != 0, BW'($urandom), rdy, 1'b0);
            budget--;
        end
        chk("feed_budget", acc_cnt, target);
    endtask

    initial begin
        logic [BW-1:0] c26;
        int            fd0;
        rst_n_i      = 1'b0;
        coef_i       = '0;
        coef_valid_i = 1'b0;
        flush_i      = 1'b0;
        ready_i      = 1'b0;
        #1;
        chk("rst_valid", valid_o, 0);
        chk("rst_last", last_o, 0);
        chk("rst_fd", frame_done_o, 0);
        chk("rst_data", data_o, 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n_i = 1'b1;
        @(posedge clk);
        #1;
        armed = 1;
        chk("rst_ready", coef_ready_o, 1);

        // single vector 1..13
        for (int i = 1; i <= VL; i++) step(1'b1, BW'(i), 1'b1, 1'b0);
        chk("sv_valid", valid_o, 1);
        chk("sv_lo", data_o[7:0], 8'd1);
        chk("sv_hi", data_o[103:96], 8'd13);
        chk("sv_last", last_o, 0);
        step(1'b0, '0, 1'b1, 1'b0);

        // full frame from a clean start
        step(1'b0, '0, 1'b0, 1'b1);
        fd0 = fd_seen;
        hs_seen = 0;
        last_at = -1;
        feed_rand(FL * VL, 1'b1);
        step(1'b0, '0, 1'b1, 1'b0);
        chk("ff_pulses", fd_seen - fd0, 1);
        chk("ff_last_at", last_at, FL);
        feed_rand(VL, 1'b1);
        step(1'b0, '0, 1'b1, 1'b0);

        // backpressure: 26 coefficients with ready low
        step(1'b0, '0, 1'b0, 1'b1);
        for (int i = 0; i < 2*VL - 1; i++) step(1'b1, BW'($urandom), 1'b0, 1'b0);
        c26 = BW'($urandom);
        step(1'b1, c26, 1'b0, 1'b0);
        step(1'b1, c26, 1'b0, 1'b0);
        chk("bp_blocked", coef_ready_o, 0);
        step(1'b1, c26, 1'b1, 1'b0);
        chk("bp_no_bubble", valid_o, 1);
        step(1'b0, '0, 1'b1, 1'b0);
        step(1'b0, '0, 1'b1, 1'b0);

        // flush mid-vector then 13 x 0x55
        for (int i = 0; i < 7; i++) step(1'b1, BW'($urandom), 1'b1, 1'b0);
        step(1'b1, 8'hAA, 1'b1, 1'b1);
        for (int i = 0; i < VL; i++) step(1'b1, 8'h55, 1'b0, 1'b0);
        chk("fl_data", data_o, {VL{8'h55}});
        chk("fl_last", last_o, 0);
        step(1'b0, '0, 1'b1, 1'b0);

        // flush coincident with the handshake of vector 49
        step(1'b0, '0, 1'b0, 1'b1);
        feed_rand((FL - 1) * VL, 1'b1);
        for (int i = 0; i < VL - 1; i++) step(1'b1, BW'($urandom), 1'b1, 1'b0);
        step(1'b1, BW'($urandom), 1'b0, 1'b0);
        step(1'b0, '0, 1'b0, 1'b0);
        chk("h49_last", last_o, 1);
        coef_valid_i = 1'b0;
        ready_i      = 1'b1;
        flush_i      = 1'b1;
        #1;
        chk("h49_fd", frame_done_o, 0);
        step(1'b0, '0, 1'b1, 1'b1);
        chk("h49_valid", valid_o, 0);
        step(1'b0, '0, 1'b1, 1'b0);

        // asynchronous reset mid-frame
        feed_rand(3 * VL + 5, 1'b1);
        coef_valid_i = 1'b1;
        ready_i      = 1'b0;
        #2;
        rst_n_i = 1'b0;
        #1;
        chk("ar_valid", valid_o, 0);
        chk("ar_last", last_o, 0);
        chk("ar_fd", frame_done_o, 0);
        chk("ar_data", data_o, 0);
        model_clear();
        armed = 0;
        @(negedge clk);
        rst_n_i = 1'b1;
        @(posedge clk);
        #1;
        armed = 1;
        fd0 = fd_seen;
        hs_seen = 0;
        last_at = -1;
        feed_rand(FL * VL, 1'b1);
        step(1'b0, '0, 1'b1, 1'b0);
        chk("ar_last_at", last_at, FL);
        chk("ar_pulses", fd_seen - fd0, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
